vco_freq_lock_ctrl: RTL and testbench

- Digital frequency-locking controller that drives the `vco` block's `voltage_ctrl_i`.
- Measures VCO output frequency by counting `vco_clk_i` rising edges over a fixed window of `clk_i` cycles.
- Compares the count with a programmed target and steps the control word with a halving-step search until in tolerance, then tracks.
- Sits between the `vco` model and system config; replaces open-loop control-word programming.

---
 rtl/vco_freq_lock_ctrl_if.sv | 21 ++
 rtl/vco_freq_lock_ctrl.sv | 152 +++++++++++++++
 tb/tb_vco_freq_lock_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vco_freq_lock_ctrl_if.sv
// vco_freq_lock_ctrl_if: config and status bundle between the system and the VCO lock controller
interface vco_freq_lock_ctrl_if #(
  parameter int RESOLUTION_BITS = 30,
  parameter int COUNT_BITS = 16
);
  logic en_i;
  logic [COUNT_BITS-1:0] target_count_i;
  logic [RESOLUTION_BITS-1:0] voltage_ctrl_o;
  logic [COUNT_BITS-1:0] meas_count_o;
  logic meas_valid_o;
  logic locked_o;
  logic busy_o;
  modport master (
    output en_i, target_count_i,
    input voltage_ctrl_o, meas_count_o, meas_valid_o, locked_o, busy_o
  );
  modport slave (
    input en_i, target_count_i,
    output voltage_ctrl_o, meas_count_o, meas_valid_o, locked_o, busy_o
  );
endinterface

// File: rtl/vco_freq_lock_ctrl.sv
// vco_freq_lock_ctrl: counts VCO edges per window and steers the control word by halving-step search, then tracks
module vco_freq_lock_ctrl #(
  parameter int RESOLUTION_BITS = 30,
  parameter int COUNT_BITS = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter longint unsigned INIT_STEP = 2**(RESOLUTION_BITS-2),
  parameter int TOLERANCE = 1,
  parameter int LOCK_WINDOWS = 4
) (
  input logic clk_i,
  input logic arst_ni,
  input logic vco_clk_i,
  vco_freq_lock_ctrl_if.slave bus
);
  localparam int CYC_W = $clog2(WINDOW_CYCLES > SETTLE_CYCLES ? WINDOW_CYCLES : SETTLE_CYCLES);
  localparam int IB_W = $clog2(LOCK_WINDOWS + 1);
  localparam int ERR_W = COUNT_BITS + 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [IB_W-1:0] LOCK_N = IB_W'(LOCK_WINDOWS);
  localparam logic signed [ERR_W-1:0] TOL = ERR_W'(TOLERANCE);
  localparam logic [RESOLUTION_BITS-1:0] STEP_INIT = RESOLUTION_BITS'(INIT_STEP);
  localparam logic [RESOLUTION_BITS-1:0] STEP_MIN = RESOLUTION_BITS'(1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, ADJUST} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;
  state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [COUNT_BITS-1:0] edge_q, edge_d, target_q, target_d, meas_q, meas_d;
  logic [RESOLUTION_BITS-1:0] ctrl_q, ctrl_d, step_q, step_d;
  logic [IB_W-1:0] inband_q, inband_d;
  logic valid_q, valid_d, locked_q, locked_d, busy_q, busy_d;
  logic edge_pulse, in_band, too_low, reverse;
  logic [COUNT_BITS-1:0] edge_sum;
  logic signed [ERR_W-1:0] err;
  logic [RESOLUTION_BITS-1:0] step_half, step_use, ctrl_up, ctrl_dn;
  logic [RESOLUTION_BITS:0] sum_up;
  logic [IB_W-1:0] inband_inc;
  assign edge_pulse = sync_q[1] & ~prev_q;
  assign edge_sum = &edge_q ? edge_q : edge_q + COUNT_BITS'(edge_pulse);
  assign err = $signed({1'b0, meas_q}) - $signed({1'b0, target_q});
  assign in_band = err <= TOL && err >= -TOL;
  assign too_low = err < -TOL;
  assign reverse = too_low ? dir_q == DIR_DN : dir_q == DIR_UP;
  assign step_half = step_q[RESOLUTION_BITS-1:1] == '0 ? STEP_MIN : step_q >> 1;
  // losing lock means the loop was already close: track in unit steps instead of re-searching
  assign step_use = locked_q ? STEP_MIN : reverse ? step_half : step_q;
  assign sum_up = {1'b0, ctrl_q} + {1'b0, step_use};
  assign ctrl_up = sum_up[RESOLUTION_BITS] ? '1 : sum_up[RESOLUTION_BITS-1:0];
  assign ctrl_dn = step_use > ctrl_q ? '0 : ctrl_q - step_use;
  assign inband_inc = inband_q == LOCK_N ? inband_q : inband_q + 1'b1;
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    sync_d = {sync_q[0], vco_clk_i};
    prev_d = sync_q[1];
    cnt_d = cnt_q + 1'b1;
    edge_d = edge_q;
    target_d = target_q;
    meas_d = meas_q;
    ctrl_d = ctrl_q;
    step_d = step_q;
    inband_d = inband_q;
    valid_d = 1'b0;
    locked_d = locked_q;
    if (!bus.en_i) begin
      state_d = IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d = '0;
          step_d = STEP_INIT;
          dir_d = DIR_NONE;
          inband_d = '0;
        end
        SETTLE: if (cnt_q == SETTLE_LAST) begin
          state_d = MEASURE;
          cnt_d = '0;
          edge_d = '0;
          target_d = bus.target_count_i;
        end
        MEASURE: begin
          edge_d = edge_sum;
          if (cnt_q == WINDOW_LAST) begin
            meas_d = edge_sum;
            valid_d = 1'b1;
            state_d = ADJUST;
          end
        end
        default: if (in_band) begin
          inband_d = inband_inc;
          locked_d = locked_q | (inband_inc == LOCK_N);
          state_d = MEASURE;
          cnt_d = '0;
          edge_d = '0;
          target_d = bus.target_count_i;
        end else begin
          dir_d = too_low ? DIR_UP : DIR_DN;
          step_d = step_use;
          ctrl_d = too_low ? ctrl_up : ctrl_dn;
          inband_d = '0;
          locked_d = 1'b0;
          state_d = SETTLE;
          cnt_d = '0;
        end
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state_q <= IDLE;
      dir_q <= DIR_NONE;
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q <= '0;
      edge_q <= '0;
      target_q <= '0;
      meas_q <= '0;
      ctrl_q <= '0;
      step_q <= STEP_INIT;
      inband_q <= '0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      edge_q <= edge_d;
      target_q <= target_d;
      meas_q <= meas_d;
      ctrl_q <= ctrl_d;
      step_q <= step_d;
      inband_q <= inband_d;
      valid_q <= valid_d;
      locked_q <= locked_d;
      busy_q <= busy_d;
    end
  assign bus.voltage_ctrl_o = ctrl_q;
  assign bus.meas_count_o = meas_q;
  assign bus.meas_valid_o = valid_q;
  assign bus.locked_o = locked_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_vco_freq_lock_ctrl.sv
// tb_vco_freq_lock_ctrl: directed lock, retarget, abort, saturation and async-reset scenarios against an arithmetic model
module tb_vco_freq_lock_ctrl;
  localparam int RB = 8, CB = 16, WIN = 64, SET = 16, INIT = 64, TOL = 1, LOCKN = 4;
  localparam int CMAX = 255, FMAX = 28;
  logic clk = 1'b0, arst_ni = 1'b0, vco_clk;
  logic [5:0] acc = '0;
  int total = 0, bad = 0, n_valid = 0;
  vco_freq_lock_ctrl_if #(.RESOLUTION_BITS(RB), .COUNT_BITS(CB)) bus();
  vco_freq_lock_ctrl #(
    .RESOLUTION_BITS(RB), .COUNT_BITS(CB), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET),
    .INIT_STEP(INIT), .TOLERANCE(TOL), .LOCK_WINDOWS(LOCKN)
  ) dut (.clk_i(clk), .arst_ni(arst_ni), .vco_clk_i(vco_clk), .bus(bus));
  always #5 clk = ~clk;
  // edges per window as a function of the control word, clamped like a VCO at its top frequency
  function automatic int vco_count(input int c);
    int f;
    f = (c * 3) / 16;
    return f > FMAX ? FMAX : f;
  endfunction
  // phase accumulator modulo the window length: every window holds exactly vco_count() rising edges
  always @(negedge clk) acc <= acc + 6'(vco_count(int'(bus.voltage_ctrl_o)));
  assign vco_clk = acc[5];
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  typedef enum {P_OFF, P_WAIT, P_WIN, P_DECIDE} ph_t;
  ph_t ph = P_OFF;
  int left = 0, m_ctrl = 0, m_step = INIT, m_dir = 0, m_good = 0, m_tgt = 0, m_meas = 0, e = 0, d = 0;
  bit m_lock = 1'b0, m_valid = 1'b0;
  initial forever begin
    @(posedge clk or negedge arst_ni);
    if (!arst_ni) begin
      ph = P_OFF; m_ctrl = 0; m_meas = 0; m_valid = 0; m_lock = 0; m_step = INIT; m_dir = 0; m_good = 0;
    end else begin
      m_valid = 0;
      if (!bus.en_i) begin
        ph = P_OFF; m_lock = 0;
      end else if (ph == P_OFF) begin
        ph = P_WAIT; left = SET; m_step = INIT; m_dir = 0; m_good = 0;
      end else if (ph == P_WAIT) begin
        left--;
        if (left == 0) begin ph = P_WIN; left = WIN; m_tgt = int'(bus.target_count_i); end
      end else if (ph == P_WIN) begin
        left--;
        if (left == 0) begin m_meas = vco_count(m_ctrl); m_valid = 1; ph = P_DECIDE; end
      end else begin
        e = m_meas - m_tgt;
        if (e >= -TOL && e <= TOL) begin
          m_good = m_good < LOCKN ? m_good + 1 : LOCKN;
          if (m_good == LOCKN) m_lock = 1;
          ph = P_WIN; left = WIN; m_tgt = int'(bus.target_count_i);
        end else begin
          d = e < 0 ? 1 : -1;
          if (m_lock) m_step = 1;
          else if (m_dir == -d) m_step = m_step > 1 ? m_step / 2 : 1;
          m_dir = d;
          m_ctrl = m_ctrl + d * m_step;
          if (m_ctrl > CMAX) m_ctrl = CMAX;
          if (m_ctrl < 0) m_ctrl = 0;
          m_good = 0; m_lock = 0; ph = P_WAIT; left = SET;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    check("ctrl", bus.voltage_ctrl_o, m_ctrl);
    check("meas", bus.meas_count_o, m_meas);
    check("valid", bus.meas_valid_o, m_valid);
    check("locked", bus.locked_o, m_lock);
    check("busy", bus.busy_o, ph != P_OFF);
    if (bus.meas_valid_o) n_valid++;
  end
  task automatic wait_locked(input bit want, input int budget, input string name);
    int n = 0;
    while (bus.locked_o !== want && n < budget) begin @(negedge clk); n++; end
    check(name, bus.locked_o, want);
  endtask
  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.meas_valid_o !== 1'b1 && n < budget);
    check(name, bus.meas_valid_o, 1);
  endtask
  initial begin
    int n, nv;
    bus.en_i = 1'b0;
    bus.target_count_i = 16'd16;
    repeat (10) @(negedge clk);
    arst_ni = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ctrl", bus.voltage_ctrl_o, 0);
    check("idle_busy", bus.busy_o, 0);
    check("idle_valid_count", n_valid, 0);
    bus.en_i = 1'b1;
    wait_locked(1, 3000, "lock1_timeout");
    check("lock1_ctrl", bus.voltage_ctrl_o, 80);
    check("lock1_meas", bus.meas_count_o, 15);
    check("lock1_windows", n_valid, 9);
    repeat (20) @(negedge clk);
    bus.target_count_i = 16'd8;
    wait_valid(200, "old_window_timeout");
    check("old_window_meas", bus.meas_count_o, 15);
    @(negedge clk);
    check("old_window_keeps_lock", bus.locked_o, 1);
    wait_valid(200, "new_window_timeout");
    @(negedge clk);
    check("new_target_drops_lock", bus.locked_o, 0);
    wait_locked(1, 6000, "lock2_timeout");
    check("lock2_ctrl", bus.voltage_ctrl_o, 53);
    check("lock2_meas", bus.meas_count_o, 9);
    repeat (30) @(negedge clk);
    bus.en_i = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy_o, 0);
    check("abort_locked", bus.locked_o, 0);
    check("abort_ctrl", bus.voltage_ctrl_o, 53);
    nv = n_valid;
    repeat (100) @(negedge clk);
    check("abort_no_valid", n_valid, nv);
    bus.target_count_i = 16'hFFFF;
    bus.en_i = 1'b1;
    n = 0;
    while (bus.voltage_ctrl_o == 8'd53 && n < 500) begin @(negedge clk); n++; end
    check("reenable_init_step", bus.voltage_ctrl_o, 117);
    n = 0;
    while (bus.voltage_ctrl_o != 8'd255 && n < 2000) begin @(negedge clk); n++; end
    check("sat_reached", bus.voltage_ctrl_o, 255);
    for (int i = 0; i < 3; i++) begin
      wait_valid(300, "sat_window_timeout");
      check("sat_meas", bus.meas_count_o, FMAX);
      check("sat_locked", bus.locked_o, 0);
      check("sat_no_wrap", bus.voltage_ctrl_o, 255);
    end
    bus.target_count_i = 16'd16;
    wait_locked(1, 3000, "lock3_timeout");
    check("lock3_ctrl", bus.voltage_ctrl_o, 95);
    check("lock3_meas", bus.meas_count_o, 17);
    @(posedge clk);
    #2 arst_ni = 1'b0;
    #1;
    check("arst_ctrl", bus.voltage_ctrl_o, 0);
    check("arst_meas", bus.meas_count_o, 0);
    check("arst_valid", bus.meas_valid_o, 0);
    check("arst_locked", bus.locked_o, 0);
    check("arst_busy", bus.busy_o, 0);
    repeat (3) @(negedge clk);
    arst_ni = 1'b1;
    n_valid = 0;
    wait_locked(1, 3000, "lock4_timeout");
    check("lock4_ctrl", bus.voltage_ctrl_o, 80);
    check("lock4_windows", n_valid, 9);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
